// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: IDLE -> EXEC -> RESP, one op per 3 cycles.
// Define TLB_FILL_LFSR_EN to draw the TLBFILL index from a 4-bit LFSR instead of a counter.
module tlb_op_ctrl (
  input  logic        clk,
  input  logic        reset,
  // request from execute stage
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_inv_op,
  input  logic [9:0]  req_inv_asid,
  input  logic [18:0] req_inv_va,
  input  logic [31:0] csr_tlbidx,
  input  logic [31:0] csr_tlbehi,
  input  logic [31:0] csr_tlbelo0,
  input  logic [31:0] csr_tlbelo1,
  input  logic [9:0]  csr_asid,
  // TLB search port 1
  output logic        s1_sel,
  output logic [18:0] s1_vppn,
  output logic        s1_va_bit12,
  output logic [9:0]  s1_asid,
  input  logic        s1_found,
  input  logic [3:0]  s1_index,
  // TLB invalidate port
  output logic        invtlb_valid,
  output logic [4:0]  invtlb_op,
  // TLB write port
  output logic        we,
  output logic [3:0]  w_index,
  output logic        w_e,
  output logic [18:0] w_vppn,
  output logic [9:0]  w_asid,
  output logic        w_g,
  output logic [5:0]  w_ps,
  output logic [19:0] w_ppn0,
  output logic [1:0]  w_plv0,
  output logic [1:0]  w_mat0,
  output logic        w_d0,
  output logic        w_v0,
  output logic [19:0] w_ppn1,
  output logic [1:0]  w_plv1,
  output logic [1:0]  w_mat1,
  output logic        w_d1,
  output logic        w_v1,
  // TLB read port
  output logic [3:0]  r_index,
  input  logic        r_e,
  input  logic [18:0] r_vppn,
  input  logic [9:0]  r_asid,
  input  logic        r_g,
  input  logic [5:0]  r_ps,
  input  logic [19:0] r_ppn0,
  input  logic [1:0]  r_plv0,
  input  logic [1:0]  r_mat0,
  input  logic        r_d0,
  input  logic        r_v0,
  input  logic [19:0] r_ppn1,
  input  logic [1:0]  r_plv1,
  input  logic [1:0]  r_mat1,
  input  logic        r_d1,
  input  logic        r_v1,
  // CSR update response
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [4:0]  rsp_mask,
  output logic [31:0] rsp_tlbidx,
  output logic [31:0] rsp_tlbehi,
  output logic [31:0] rsp_tlbelo0,
  output logic [31:0] rsp_tlbelo1,
  output logic [9:0]  rsp_asid
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [2:0] OpSrch = 3'd0;
  localparam logic [2:0] OpRd   = 3'd1;
  localparam logic [2:0] OpWr   = 3'd2;
  localparam logic [2:0] OpFill = 3'd3;
  localparam logic [2:0] OpInv  = 3'd4;
  localparam logic [4:0] InvOpMax = 5'd6;

`ifdef TLB_FILL_LFSR_EN
  localparam logic [3:0] FillSeed = 4'b0001;
`else
  localparam logic [3:0] FillSeed = 4'b0000;
`endif

  state_e      state_q, state_d;
  logic [3:0]  fill_q, fill_d;
  logic [3:0]  fill_lat_q, fill_lat_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  inv_op_q, inv_op_d;
  logic [9:0]  inv_asid_q, inv_asid_d;
  logic [18:0] inv_va_q, inv_va_d;
  logic [3:0]  idx_index_q, idx_index_d;
  logic [5:0]  idx_ps_q, idx_ps_d;
  logic        idx_ne_q, idx_ne_d;
  logic [18:0] vppn_q, vppn_d;
  // Packed EntryLo: {ppn[19:0], g, mat[1:0], plv[1:0], d, v}
  logic [26:0] elo0_q, elo0_d;
  logic [26:0] elo1_q, elo1_d;
  logic [9:0]  asid_q, asid_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [4:0]  rsp_mask_q, rsp_mask_d;
  logic [31:0] rsp_tlbidx_q, rsp_tlbidx_d;
  logic [31:0] rsp_tlbehi_q, rsp_tlbehi_d;
  logic [31:0] rsp_tlbelo0_q, rsp_tlbelo0_d;
  logic [31:0] rsp_tlbelo1_q, rsp_tlbelo1_d;
  logic [9:0]  rsp_asid_q, rsp_asid_d;

  logic in_exec, inv_bad, op_err;
  logic do_srch, do_rd, do_wr, do_inv;

  logic unused_csr_bits;
  assign unused_csr_bits = ^{csr_tlbidx[30], csr_tlbidx[23:4], csr_tlbehi[12:0],
                             csr_tlbelo0[31:28], csr_tlbelo0[7],
                             csr_tlbelo1[31:28], csr_tlbelo1[7]};

`ifdef TLB_FILL_LFSR_EN
  assign fill_d = {fill_q[2:0], fill_q[3] ^ fill_q[2]};
`else
  assign fill_d = fill_q + 4'd1;
`endif

  assign req_ready = (state_q == StIdle) && !reset;

  assign in_exec = (state_q == StExec);
  assign inv_bad = (op_q == OpInv) && (inv_op_q > InvOpMax);
  assign op_err  = (op_q > OpInv) || inv_bad;
  assign do_srch = in_exec && (op_q == OpSrch);
  assign do_rd   = in_exec && (op_q == OpRd);
  assign do_wr   = in_exec && ((op_q == OpWr) || (op_q == OpFill));
  assign do_inv  = in_exec && (op_q == OpInv) && !inv_bad;

  // Next state and request capture
  always_comb begin
    state_d     = state_q;
    fill_lat_d  = fill_lat_q;
    op_d        = op_q;
    inv_op_d    = inv_op_q;
    inv_asid_d  = inv_asid_q;
    inv_va_d    = inv_va_q;
    idx_index_d = idx_index_q;
    idx_ps_d    = idx_ps_q;
    idx_ne_d    = idx_ne_q;
    vppn_d      = vppn_q;
    elo0_d      = elo0_q;
    elo1_d      = elo1_q;
    asid_d      = asid_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d     = StExec;
          fill_lat_d  = fill_q;
          op_d        = req_op;
          inv_op_d    = req_inv_op;
          inv_asid_d  = req_inv_asid;
          inv_va_d    = req_inv_va;
          idx_index_d = csr_tlbidx[3:0];
          idx_ps_d    = csr_tlbidx[29:24];
          idx_ne_d    = csr_tlbidx[31];
          vppn_d      = csr_tlbehi[31:13];
          elo0_d      = {csr_tlbelo0[27:8], csr_tlbelo0[6:0]};
          elo1_d      = {csr_tlbelo1[27:8], csr_tlbelo1[6:0]};
          asid_d      = csr_asid;
        end
      end
      StExec:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Response values, captured at the end of EXEC so TLB results are registered
  always_comb begin
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_mask_d    = 5'd0;
    rsp_tlbidx_d  = 32'd0;
    rsp_tlbehi_d  = 32'd0;
    rsp_tlbelo0_d = 32'd0;
    rsp_tlbelo1_d = 32'd0;
    rsp_asid_d    = 10'd0;
    if (in_exec) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = op_err;
      if (op_q == OpSrch) begin
        rsp_mask_d   = 5'b00001;
        rsp_tlbidx_d = {~s1_found, 1'b0, idx_ps_q, 20'd0,
                        s1_found ? s1_index : idx_index_q};
      end else if (op_q == OpRd) begin
        rsp_mask_d = 5'b11111;
        if (r_e) begin
          rsp_tlbidx_d  = {2'b00, r_ps, 20'd0, idx_index_q};
          rsp_tlbehi_d  = {r_vppn, 13'd0};
          rsp_tlbelo0_d = {4'd0, r_ppn0, 1'b0, r_g, r_mat0, r_plv0, r_d0, r_v0};
          rsp_tlbelo1_d = {4'd0, r_ppn1, 1'b0, r_g, r_mat1, r_plv1, r_d1, r_v1};
          rsp_asid_d    = r_asid;
        end else begin
          rsp_tlbidx_d = {1'b1, 27'd0, idx_index_q};
        end
      end
    end
  end

  // TLB port drive is combinational from state so reset kills it immediately
  always_comb begin
    s1_sel       = do_srch || do_inv;
    s1_va_bit12  = 1'b0;
    s1_vppn      = 19'd0;
    s1_asid      = 10'd0;
    if (do_srch) begin
      s1_vppn = vppn_q;
      s1_asid = asid_q;
    end else if (do_inv) begin
      s1_vppn = inv_va_q;
      s1_asid = inv_asid_q;
    end
    invtlb_valid = do_inv;
    invtlb_op    = do_inv ? inv_op_q : 5'd0;
    r_index      = do_rd ? idx_index_q : 4'd0;

    we     = do_wr;
    w_index = 4'd0;
    w_e    = 1'b0;
    w_vppn = 19'd0;
    w_asid = 10'd0;
    w_g    = 1'b0;
    w_ps   = 6'd0;
    w_ppn0 = 20'd0;
    w_plv0 = 2'd0;
    w_mat0 = 2'd0;
    w_d0   = 1'b0;
    w_v0   = 1'b0;
    w_ppn1 = 20'd0;
    w_plv1 = 2'd0;
    w_mat1 = 2'd0;
    w_d1   = 1'b0;
    w_v1   = 1'b0;
    if (do_wr) begin
      w_index = (op_q == OpFill) ? fill_lat_q : idx_index_q;
      w_e    = ~idx_ne_q;
      w_vppn = vppn_q;
      w_asid = asid_q;
      w_g    = elo0_q[6] & elo1_q[6];
      w_ps   = idx_ps_q;
      w_ppn0 = elo0_q[26:7];
      w_mat0 = elo0_q[5:4];
      w_plv0 = elo0_q[3:2];
      w_d0   = elo0_q[1];
      w_v0   = elo0_q[0];
      w_ppn1 = elo1_q[26:7];
      w_mat1 = elo1_q[5:4];
      w_plv1 = elo1_q[3:2];
      w_d1   = elo1_q[1];
      w_v1   = elo1_q[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      fill_q        <= FillSeed;
      fill_lat_q    <= 4'd0;
      op_q          <= 3'd0;
      inv_op_q      <= 5'd0;
      inv_asid_q    <= 10'd0;
      inv_va_q      <= 19'd0;
      idx_index_q   <= 4'd0;
      idx_ps_q      <= 6'd0;
      idx_ne_q      <= 1'b0;
      vppn_q        <= 19'd0;
      elo0_q        <= 27'd0;
      elo1_q        <= 27'd0;
      asid_q        <= 10'd0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_mask_q    <= 5'd0;
      rsp_tlbidx_q  <= 32'd0;
      rsp_tlbehi_q  <= 32'd0;
      rsp_tlbelo0_q <= 32'd0;
      rsp_tlbelo1_q <= 32'd0;
      rsp_asid_q    <= 10'd0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      fill_lat_q    <= fill_lat_d;
      op_q          <= op_d;
      inv_op_q      <= inv_op_d;
      inv_asid_q    <= inv_asid_d;
      inv_va_q      <= inv_va_d;
      idx_index_q   <= idx_index_d;
      idx_ps_q      <= idx_ps_d;
      idx_ne_q      <= idx_ne_d;
      vppn_q        <= vppn_d;
      elo0_q        <= elo0_d;
      elo1_q        <= elo1_d;
      asid_q        <= asid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_mask_q    <= rsp_mask_d;
      rsp_tlbidx_q  <= rsp_tlbidx_d;
      rsp_tlbehi_q  <= rsp_tlbehi_d;
      rsp_tlbelo0_q <= rsp_tlbelo0_d;
      rsp_tlbelo1_q <= rsp_tlbelo1_d;
      rsp_asid_q    <= rsp_asid_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_mask    = rsp_mask_q;
  assign rsp_tlbidx  = rsp_tlbidx_q;
  assign rsp_tlbehi  = rsp_tlbehi_q;
  assign rsp_tlbelo0 = rsp_tlbelo0_q;
  assign rsp_tlbelo1 = rsp_tlbelo1_q;
  assign rsp_asid    = rsp_asid_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: vector table against a small 16-entry TLB model,
// plus hand sequences for reset-in-EXEC and back-to-back request throttling.
module tb_tlb_op_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic model_init = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [4:0]  req_inv_op = 5'd0;
  logic [9:0]  req_inv_asid = 10'd0;
  logic [18:0] req_inv_va = 19'd0;
  logic [31:0] csr_tlbidx = 32'd0, csr_tlbehi = 32'd0, csr_tlbelo0 = 32'd0, csr_tlbelo1 = 32'd0;
  logic [9:0]  csr_asid = 10'd0;
  logic        s1_sel, s1_va_bit12, s1_found;
  logic [18:0] s1_vppn;
  logic [9:0]  s1_asid;
  logic [3:0]  s1_index;
  logic        invtlb_valid;
  logic [4:0]  invtlb_op;
  logic        we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  w_index;
  logic [18:0] w_vppn;
  logic [9:0]  w_asid;
  logic [5:0]  w_ps;
  logic [19:0] w_ppn0, w_ppn1;
  logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
  logic [3:0]  r_index;
  logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic [18:0] r_vppn;
  logic [9:0]  r_asid;
  logic [5:0]  r_ps;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;
  logic        rsp_valid, rsp_err;
  logic [4:0]  rsp_mask;
  logic [31:0] rsp_tlbidx, rsp_tlbehi, rsp_tlbelo0, rsp_tlbelo1;
  logic [9:0]  rsp_asid;

  tlb_op_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_va(req_inv_va),
    .csr_tlbidx(csr_tlbidx), .csr_tlbehi(csr_tlbehi),
    .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1), .csr_asid(csr_asid),
    .s1_sel(s1_sel), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_asid(w_asid), .w_g(w_g),
    .w_ps(w_ps), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
    .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_asid(r_asid), .r_g(r_g), .r_ps(r_ps),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_mask(rsp_mask),
    .rsp_tlbidx(rsp_tlbidx), .rsp_tlbehi(rsp_tlbehi),
    .rsp_tlbelo0(rsp_tlbelo0), .rsp_tlbelo1(rsp_tlbelo1), .rsp_asid(rsp_asid)
  );

  // Minimal TLB: junk in every field of invalid entries so RD masking is visible
  logic        m_e [16];
  logic        m_g [16];
  logic [18:0] m_vppn [16];
  logic [9:0]  m_asid [16];
  logic [5:0]  m_ps [16];
  logic [19:0] m_ppn0 [16], m_ppn1 [16];
  logic [1:0]  m_plv0 [16], m_mat0 [16], m_plv1 [16], m_mat1 [16];
  logic        m_d0 [16], m_v0 [16], m_d1 [16], m_v1 [16];

  always @(posedge clk) begin
    if (model_init) begin
      for (int i = 0; i < 16; i++) begin
        m_e[i] <= 1'b0; m_g[i] <= 1'b1; m_vppn[i] <= 19'h70000 | 19'(i);
        m_asid[i] <= 10'h3FF; m_ps[i] <= 6'd21;
        m_ppn0[i] <= 20'hFFFFF; m_ppn1[i] <= 20'hFFFFF;
        m_plv0[i] <= 2'd3; m_mat0[i] <= 2'd3; m_plv1[i] <= 2'd3; m_mat1[i] <= 2'd3;
        m_d0[i] <= 1'b1; m_v0[i] <= 1'b1; m_d1[i] <= 1'b1; m_v1[i] <= 1'b1;
      end
    end else begin
      if (we) begin
        m_e[w_index] <= w_e; m_g[w_index] <= w_g; m_vppn[w_index] <= w_vppn;
        m_asid[w_index] <= w_asid; m_ps[w_index] <= w_ps;
        m_ppn0[w_index] <= w_ppn0; m_plv0[w_index] <= w_plv0; m_mat0[w_index] <= w_mat0;
        m_d0[w_index] <= w_d0; m_v0[w_index] <= w_v0;
        m_ppn1[w_index] <= w_ppn1; m_plv1[w_index] <= w_plv1; m_mat1[w_index] <= w_mat1;
        m_d1[w_index] <= w_d1; m_v1[w_index] <= w_v1;
      end
      if (invtlb_valid) begin
        for (int i = 0; i < 16; i++) begin
          if (invtlb_op <= 5'd1) m_e[i] <= 1'b0;
          else if (invtlb_op == 5'd5 && !m_g[i] && m_asid[i] == s1_asid &&
                   m_vppn[i] == s1_vppn) m_e[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    s1_found = 1'b0;
    s1_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!s1_found && m_e[i] && m_vppn[i] == s1_vppn && (m_g[i] || m_asid[i] == s1_asid)) begin
        s1_found = 1'b1;
        s1_index = 4'(i);
      end
    end
  end

  assign r_e = m_e[r_index];     assign r_g = m_g[r_index];
  assign r_vppn = m_vppn[r_index]; assign r_asid = m_asid[r_index];
  assign r_ps = m_ps[r_index];
  assign r_ppn0 = m_ppn0[r_index]; assign r_plv0 = m_plv0[r_index];
  assign r_mat0 = m_mat0[r_index]; assign r_d0 = m_d0[r_index]; assign r_v0 = m_v0[r_index];
  assign r_ppn1 = m_ppn1[r_index]; assign r_plv1 = m_plv1[r_index];
  assign r_mat1 = m_mat1[r_index]; assign r_d1 = m_d1[r_index]; assign r_v1 = m_v1[r_index];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] idx, ehi, elo0, elo1;
    logic [9:0]  asid;
    logic [4:0]  iop;
    logic [9:0]  iasid;
    logic [18:0] iva;
    logic        x_we;
    logic [3:0]  x_widx;
    logic        x_inv, x_s1, x_err;
    logic [4:0]  x_mask;
    logic [31:0] x_idx, x_ehi, x_elo0, x_elo1;
    logic [9:0]  x_asid;
  } vec_t;

`ifdef TLB_FILL_LFSR_EN
  localparam logic [3:0] FirstFill = 4'd4;
`else
  localparam logic [3:0] FirstFill = 4'd2;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] idx, input logic [31:0] ehi,
                              input logic [31:0] elo0, input logic [31:0] elo1,
                              input logic [9:0] asid, input logic [4:0] iop,
                              input logic [9:0] iasid, input logic [18:0] iva,
                              input logic x_we, input logic [3:0] x_widx, input logic x_inv,
                              input logic x_s1, input logic x_err, input logic [4:0] x_mask,
                              input logic [31:0] x_idx, input logic [31:0] x_ehi,
                              input logic [31:0] x_elo0, input logic [31:0] x_elo1,
                              input logic [9:0] x_asid);
    vec_t v;
    v.op = op; v.idx = idx; v.ehi = ehi; v.elo0 = elo0; v.elo1 = elo1; v.asid = asid;
    v.iop = iop; v.iasid = iasid; v.iva = iva;
    v.x_we = x_we; v.x_widx = x_widx; v.x_inv = x_inv; v.x_s1 = x_s1; v.x_err = x_err;
    v.x_mask = x_mask; v.x_idx = x_idx; v.x_ehi = x_ehi; v.x_elo0 = x_elo0;
    v.x_elo1 = x_elo1; v.x_asid = x_asid;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_op = v.op; csr_tlbidx = v.idx; csr_tlbehi = v.ehi; csr_tlbelo0 = v.elo0;
    csr_tlbelo1 = v.elo1; csr_asid = v.asid; req_inv_op = v.iop;
    req_inv_asid = v.iasid; req_inv_va = v.iva;
  endtask

  task automatic do_op(input int n, input vec_t v);
    int waited;
    string p;
    p = $sformatf("v%0d", n);
    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk({p, " ready_timeout"}, 32'(req_ready), 32'd1);
      return;
    end
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    // EXEC cycle
    chk({p, " exec_we"}, 32'(we), 32'(v.x_we));
    chk({p, " exec_invtlb_valid"}, 32'(invtlb_valid), 32'(v.x_inv));
    chk({p, " exec_s1_sel"}, 32'(s1_sel), 32'(v.x_s1));
    chk({p, " exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
    if (v.x_we) begin
      chk({p, " w_index"}, 32'(w_index), 32'(v.x_widx));
      chk({p, " w_e"}, 32'(w_e), 32'd1);
      chk({p, " w_g"}, 32'(w_g), 32'd0);
      chk({p, " w_vppn"}, 32'(w_vppn), 32'h12345);
      chk({p, " w_ppn0"}, 32'(w_ppn0), 32'h0001F);
    end
    if (v.x_s1) begin
      chk({p, " s1_asid"}, 32'(s1_asid), 32'(v.op == 3'd4 ? v.iasid : v.asid));
      chk({p, " s1_va_bit12"}, 32'(s1_va_bit12), 32'd0);
    end
    if (v.x_inv) chk({p, " invtlb_op"}, 32'(invtlb_op), 32'(v.iop));
    @(posedge clk);
    #1;
    // RESP cycle
    chk({p, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({p, " rsp_err"}, 32'(rsp_err), 32'(v.x_err));
    chk({p, " rsp_mask"}, 32'(rsp_mask), 32'(v.x_mask));
    chk({p, " rsp_tlbidx"}, rsp_tlbidx, v.x_idx);
    chk({p, " rsp_tlbehi"}, rsp_tlbehi, v.x_ehi);
    chk({p, " rsp_tlbelo0"}, rsp_tlbelo0, v.x_elo0);
    chk({p, " rsp_tlbelo1"}, rsp_tlbelo1, v.x_elo1);
    chk({p, " rsp_asid"}, 32'(rsp_asid), 32'(v.x_asid));
    chk({p, " resp_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({p, " post_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({p, " post_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int accepts;
    int acc_cyc[$];
    vec_t v;

    //            op     tlbidx        ehi           elo0          elo1          asid
    //            iop    iasid   iva       we widx      inv s1 err mask
    //            x_idx         x_ehi         x_elo0        x_elo1        x_asid
    vecs[0]  = mk(3'd3, 32'h0C000000, 32'h2468A000, 32'h00001F03, 32'h00000000, 10'h0AA,
                  5'd0, 10'h0, 19'h0, 1'b1, FirstFill, 1'b0, 1'b0, 1'b0, 5'h00,
                  32'h0, 32'h0, 32'h0, 32'h0, 10'h0);
    vecs[1]  = mk(3'd2, 32'h0C000005, 32'h2468A000, 32'h00001F03, 32'h00002F4B, 10'h003,
                  5'd0, 10'h0, 19'h0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 5'h00,
                  32'h0, 32'h0, 32'h0, 32'h0, 10'h0);
    vecs[2]  = mk(3'd0, 32'h0C000009, 32'h2468A000, 32'h0, 32'h0, 10'h003,
                  5'd0, 10'h0, 19'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 5'h01,
                  32'h0C000005, 32'h0, 32'h0, 32'h0, 10'h0);
    vecs[3]  = mk(3'd0, 32'h0C000009, 32'h2468A000, 32'h0, 32'h0, 10'h004,
                  5'd0, 10'h0, 19'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 5'h01,
                  32'h8C000009, 32'h0, 32'h0, 32'h0, 10'h0);
    vecs[4]  = mk(3'd1, 32'h00000005, 32'h0, 32'h0, 32'h0, 10'h0,
                  5'd0, 10'h0, 19'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'h1F,
                  32'h0C000005, 32'h2468A000, 32'h00001F03, 32'h00002F0B, 10'h003);
    vecs[5]  = mk(3'd1, 32'h0C000007, 32'h0, 32'h0, 32'h0, 10'h0,
                  5'd0, 10'h0, 19'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'h1F,
                  32'h80000007, 32'h0, 32'h0, 32'h0, 10'h0);
    vecs[6]  = mk(3'd1, 32'h00000002, 32'h0, 32'h0, 32'h0, 10'h0,
                  5'd0, 10'h0, 19'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'h1F,
                  32'h0C000002, 32'h2468A000, 32'h00001F03, 32'h0, 10'h0AA);
    vecs[7]  = mk(3'd4, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0,
                  5'd5, 10'h003, 19'h12345, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 5'h00,
                  32'h0, 32'h0, 32'h0, 32'h0, 10'h0);
    vecs[8]  = vecs[2];
    vecs[8].x_idx = 32'h8C000009;
    vecs[9]  = mk(3'd4, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0,
                  5'd9, 10'h003, 19'h12345, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 5'h00,
                  32'h0, 32'h0, 32'h0, 32'h0, 10'h0);
    vecs[10] = mk(3'd6, 32'h0C000005, 32'h2468A000, 32'h00001F03, 32'h0, 10'h003,
                  5'd0, 10'h0, 19'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 5'h00,
                  32'h0, 32'h0, 32'h0, 32'h0, 10'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset we", 32'(we), 32'd0);
    chk("reset s1_sel", 32'(s1_sel), 32'd0);
    chk("reset rsp_tlbidx", rsp_tlbidx, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_init = 1'b0;
    #1 chk("release req_ready", 32'(req_ready), 32'd1);
    // Two free-running fill-index steps before the first FILL is accepted
    @(posedge clk);
    @(posedge clk);

    for (int i = 0; i < 11; i++) do_op(i, vecs[i]);

    // Reset asserted while a WR sits in EXEC
    @(negedge clk);
    v = vecs[1];
    v.idx = 32'h0C000006;
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rst_exec we_before", 32'(we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_exec we", 32'(we), 32'd0);
    chk("rst_exec w_index", 32'(w_index), 32'd0);
    chk("rst_exec req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 chk("rst_exec rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_release req_ready", 32'(req_ready), 32'd1);
    accepts = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 if (rsp_valid) accepts++;
    end
    chk("rst_exec no_rsp", 32'(accepts), 32'd0);
    v = vecs[5];
    v.idx = 32'h00000006;
    v.x_idx = 32'h80000006;
    do_op(11, v);

    // Back-to-back: req_valid held 9 cycles
    @(negedge clk);
    drive(vecs[2]);
    req_valid = 1'b1;
    accepts = 0;
    for (int c = 0; c < 9; c++) begin
      if (req_ready) begin
        accepts++;
        acc_cyc.push_back(c);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b accepts", 32'(accepts), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b first", 32'(acc_cyc[0]), 32'd0);
      chk("b2b second", 32'(acc_cyc[1]), 32'd3);
      chk("b2b third", 32'(acc_cyc[2]), 32'd6);
    end
    repeat (4) @(negedge clk);
    chk("b2b idle_ready", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
